// File: rtl/gate_plant.sv
// Behavioural plant model of a motorised gate: tracks travel position, drives limit switches,
// enforces motor dead time on reversal/obstacle/conflict and latches a sticky conflict flag.
module gate_plant #(
  parameter int TRAVEL_CYCLES = 8,
  parameter int DEAD_CYCLES   = 2,
  parameter bit INIT_CLOSED   = 1'b1,
  localparam int PW           = $clog2(TRAVEL_CYCLES + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          abrir_i,
  input  logic          fechar_i,
  input  logic          obst_i,
  output logic          fca_o,
  output logic          fcc_o,
  output logic [PW-1:0] pos_o,
  output logic          movendo_o,
  output logic          erro_o
);

  localparam int DW = $clog2(DEAD_CYCLES + 1);
  localparam logic [PW-1:0] POS_MAX   = PW'(TRAVEL_CYCLES);
  localparam logic [PW-1:0] POS_RESET = INIT_CLOSED ? '0 : POS_MAX;
  localparam logic [DW-1:0] DEAD_LOAD = DW'(DEAD_CYCLES - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_OPENING = 2'd1;
  localparam logic [1:0] ST_CLOSING = 2'd2;
  localparam logic [1:0] ST_DEAD    = 2'd3;

  logic [1:0]    state_q, state_n;
  logic [PW-1:0] pos_q, pos_n;
  logic [DW-1:0] dead_q, dead_n;
  logic          erro_q;

  logic conflict, cmd_open, cmd_close;

  assign conflict  = abrir_i & fechar_i;
  assign cmd_open  = abrir_i & ~fechar_i;
  assign cmd_close = fechar_i & ~abrir_i & ~obst_i;

  always_comb begin
    state_n = state_q;
    pos_n   = pos_q;
    dead_n  = dead_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_open && pos_q != POS_MAX) begin
          state_n = ST_OPENING;
        end else if (cmd_close && pos_q != '0) begin
          state_n = ST_CLOSING;
        end
      end
      ST_OPENING: begin
        if (cmd_open) begin
          // Guard keeps the counter inside 0..MAX even if the limit was already reached.
          if (pos_q == POS_MAX) begin
            state_n = ST_IDLE;
          end else begin
            pos_n = pos_q + PW'(1);
            if (pos_n == POS_MAX) state_n = ST_IDLE;
          end
        end else if (fechar_i) begin
          state_n = ST_DEAD;
          dead_n  = DEAD_LOAD;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_CLOSING: begin
        if (cmd_close) begin
          if (pos_q == '0) begin
            state_n = ST_IDLE;
          end else begin
            pos_n = pos_q - PW'(1);
            if (pos_n == '0) state_n = ST_IDLE;
          end
        end else if (abrir_i || fechar_i) begin
          state_n = ST_DEAD;
          dead_n  = DEAD_LOAD;
        end else begin
          state_n = ST_IDLE;
        end
      end
      default: begin
        if (dead_q == '0) begin
          state_n = ST_IDLE;
        end else begin
          dead_n = dead_q - DW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      pos_q   <= POS_RESET;
      dead_q  <= '0;
      erro_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      pos_q   <= pos_n;
      dead_q  <= dead_n;
      if (conflict) erro_q <= 1'b1;
    end
  end

  assign pos_o     = pos_q;
  assign fca_o     = (pos_q == POS_MAX);
  assign fcc_o     = (pos_q == '0);
  assign movendo_o = (state_q == ST_OPENING) || (state_q == ST_CLOSING);
  assign erro_o    = erro_q;

endmodule

// File: tb/tb_gate_plant.sv
// Scoreboard bench for gate_plant: directed per-cycle vectors push expected state into a queue,
// a monitor pops one entry after each rising edge and compares it with the plant outputs.
module tb_gate_plant;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       abrir = 1'b0;
  logic       fechar = 1'b0;
  logic       obst = 1'b0;
  logic       fca, fcc, movendo, erro;
  logic [3:0] pos;

  typedef struct {
    string      tag;
    logic [3:0] pos;
    logic       mov;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  gate_plant #(.TRAVEL_CYCLES(8), .DEAD_CYCLES(2), .INIT_CLOSED(1'b1)) dut (
    .clk_i(clk), .rst_i(rst), .abrir_i(abrir), .fechar_i(fechar), .obst_i(obst),
    .fca_o(fca), .fcc_o(fcc), .pos_o(pos), .movendo_o(movendo), .erro_o(erro)
  );

  always #5 clk = ~clk;

  // One cycle of stimulus; the expected values describe the outputs after the next rising edge.
  task automatic applyStimulus(input logic r, input logic a, input logic f, input logic o,
                               input int ep, input logic em, input logic ee, input string tag);
    exp_t e;
    @(negedge clk);
    rst = r; abrir = a; fechar = f; obst = o;
    e.tag = tag; e.pos = 4'(ep); e.mov = em; e.err = ee;
    exp_q.push_back(e);
  endtask

  task automatic checkOutput(input string tag, input string field, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("[TB] FAIL %s.%s actual=%0d required=%0d @%0t", tag, field, act, req, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput(e.tag, "pos", int'(pos), int'(e.pos));
        checkOutput(e.tag, "fca", int'(fca), int'(e.pos == 4'd8));
        checkOutput(e.tag, "fcc", int'(fcc), int'(e.pos == 4'd0));
        checkOutput(e.tag, "movendo", int'(movendo), int'(e.mov));
        checkOutput(e.tag, "erro", int'(erro), int'(e.err));
      end
    end
  end

  initial begin : stimulus
    applyStimulus(1, 0, 0, 0, 0, 0, 0, "reset");
    applyStimulus(1, 1, 1, 1, 0, 0, 0, "reset_override");

    applyStimulus(0, 1, 0, 0, 0, 1, 0, "open_enter");
    for (int i = 1; i <= 8; i++) applyStimulus(0, 1, 0, 0, i, i < 8, 0, "open_step");
    for (int i = 0; i < 6; i++) applyStimulus(0, 1, 0, 0, 8, 0, 0, "open_hold");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, "reset2");

    applyStimulus(0, 1, 0, 0, 0, 1, 0, "rev_enter");
    for (int i = 1; i <= 3; i++) applyStimulus(0, 1, 0, 0, i, 1, 0, "rev_open");
    applyStimulus(0, 0, 1, 0, 3, 0, 0, "rev_dead1");
    applyStimulus(0, 0, 1, 0, 3, 0, 0, "rev_dead2");
    applyStimulus(0, 0, 1, 0, 3, 0, 0, "rev_idle");
    applyStimulus(0, 0, 1, 0, 3, 1, 0, "rev_close_enter");
    applyStimulus(0, 0, 1, 0, 2, 1, 0, "rev_close_step");
    applyStimulus(0, 0, 1, 0, 1, 1, 0, "rev_close_step");
    applyStimulus(0, 0, 1, 0, 0, 0, 0, "rev_closed");
    applyStimulus(0, 0, 1, 0, 0, 0, 0, "close_at_limit");

    applyStimulus(0, 1, 0, 0, 0, 1, 0, "obs_open_enter");
    for (int i = 1; i <= 5; i++) applyStimulus(0, 1, 0, 0, i, 1, 0, "obs_open");
    applyStimulus(0, 0, 0, 0, 5, 0, 0, "obs_stop");
    applyStimulus(0, 0, 1, 0, 5, 1, 0, "obs_close_enter");
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 1, 5, 0, 0, "obs_blocked");
    applyStimulus(0, 0, 1, 0, 5, 1, 0, "obs_resume");
    for (int i = 4; i >= 1; i--) applyStimulus(0, 0, 1, 0, i, 1, 0, "obs_close");
    applyStimulus(0, 0, 1, 0, 0, 0, 0, "obs_closed");

    applyStimulus(0, 1, 0, 1, 0, 1, 0, "obst_open_enter");
    applyStimulus(0, 1, 0, 1, 1, 1, 0, "obst_open_step");
    applyStimulus(0, 1, 0, 1, 2, 1, 0, "obst_open_step");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, "reset3");

    applyStimulus(0, 1, 0, 0, 0, 1, 0, "cf_enter");
    for (int i = 1; i <= 4; i++) applyStimulus(0, 1, 0, 0, i, 1, 0, "cf_open");
    applyStimulus(0, 1, 1, 0, 4, 0, 1, "cf_conflict");
    applyStimulus(0, 0, 0, 0, 4, 0, 1, "cf_dead");
    applyStimulus(0, 0, 0, 0, 4, 0, 1, "cf_idle");
    applyStimulus(0, 1, 0, 0, 4, 1, 1, "cf_reopen");
    applyStimulus(0, 1, 0, 0, 5, 1, 1, "cf_step");
    applyStimulus(0, 1, 0, 0, 6, 1, 1, "cf_step");
    applyStimulus(1, 1, 0, 0, 0, 0, 0, "reset_mid_motion");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, "after_reset");

    applyStimulus(0, 1, 1, 0, 0, 0, 1, "idle_conflict");
    applyStimulus(0, 0, 0, 0, 0, 0, 1, "err_sticky");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, "reset_clears_err");

    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
